// File: rtl/k6502_seq.sv
// k6502 instruction sequencer: captures opcodes, steps the one-hot cycle and
// arbitrates reset/NMI/IRQ entry at each instruction boundary for the decoder.
module k6502_seq #(
  parameter int CYCLE_BITS = 6,
  parameter bit NMI_EDGE   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  rdy_i,
  input  logic [7:0]            din_i,
  input  logic                  sync_next_i,
  input  logic                  i_flag_i,
  input  logic                  nmi_in_i,
  input  logic                  irq_in_i,
  output logic [7:0]            ir_o,
  output logic [CYCLE_BITS-1:0] cycle_o,
  output logic                  rst_out_o,
  output logic                  nmi_out_o,
  output logic                  irq_out_o,
  output logic                  fetch_o
);

  localparam logic [CYCLE_BITS-1:0] C_0 = {{(CYCLE_BITS-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_BITS-1:0] C_N = '0;

  // One-hot sequence type, so the request outputs are plain register bits.
  typedef enum logic [2:0] {
    SEQ_OP  = 3'b000,
    SEQ_IRQ = 3'b001,
    SEQ_NMI = 3'b010,
    SEQ_RST = 3'b100
  } seq_e;

  seq_e                  state_q, state_d;
  logic [7:0]            ir_q, ir_d;
  logic [CYCLE_BITS-1:0] cycle_q, cycle_d;
  logic                  fetch_q, fetch_d;
  logic                  nmi_hist_q;
  logic                  nmi_pend_q, nmi_pend_d;
  logic                  nmi_req, nmi_take, irq_take, boundary;

  assign boundary = rdy_i & sync_next_i;
  assign nmi_take = boundary & nmi_req;
  assign irq_take = irq_in_i & ~i_flag_i;

  generate
    if (NMI_EDGE) begin : g_nmi_edge
      logic nmi_set;
      assign nmi_set    = nmi_in_i & ~nmi_hist_q;
      assign nmi_req    = nmi_pend_q;
      // A new edge wins over the clear, so one landing on the boundary stays pending.
      assign nmi_pend_d = nmi_set | (nmi_pend_q & ~nmi_take);
    end else begin : g_nmi_level
      assign nmi_req    = nmi_in_i;
      assign nmi_pend_d = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cycle_d = cycle_q;
    if (rdy_i) begin
      if (sync_next_i) begin
        cycle_d = C_0;
        if (nmi_req) begin
          state_d = SEQ_NMI;
          ir_d    = 8'h00;
        end else if (irq_take) begin
          state_d = SEQ_IRQ;
          ir_d    = 8'h00;
        end else begin
          state_d = SEQ_OP;
          ir_d    = din_i;
        end
      end else if (cycle_q[CYCLE_BITS-1]) begin
        // Ran off the end: park on {none, 00, C_N}, which the decoder closes.
        state_d = SEQ_OP;
        ir_d    = 8'h00;
        cycle_d = C_N;
      end else begin
        cycle_d = cycle_q << 1;
      end
    end
    fetch_d = (cycle_d == C_0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= SEQ_RST;
      ir_q       <= 8'h00;
      cycle_q    <= C_0;
      fetch_q    <= 1'b1;
      nmi_hist_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      cycle_q    <= cycle_d;
      fetch_q    <= fetch_d;
      nmi_hist_q <= nmi_in_i;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign ir_o      = ir_q;
  assign cycle_o   = cycle_q;
  assign fetch_o   = fetch_q;
  assign rst_out_o = (state_q == SEQ_RST);
  assign nmi_out_o = (state_q == SEQ_NMI);
  assign irq_out_o = (state_q == SEQ_IRQ);

endmodule

// File: tb/tb_k6502_seq.sv
// Directed bench for k6502_seq: reset, stepping, IRQ mask, NMI edge/priority,
// rdy stall, overflow recovery and reset during an NMI sequence.
module tb_k6502_seq;
  logic       clk = 1'b0;
  logic       reset, rdy, sync_next, i_flag, nmi_in, irq_in;
  logic [7:0] din;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic       rst_out, nmi_out, irq_out, fetch;
  int         checks = 0;
  int         failures = 0;

  k6502_seq #(.CYCLE_BITS(6), .NMI_EDGE(1'b1)) dut (
    .clk_i(clk), .reset_i(reset), .rdy_i(rdy), .din_i(din),
    .sync_next_i(sync_next), .i_flag_i(i_flag), .nmi_in_i(nmi_in),
    .irq_in_i(irq_in), .ir_o(ir), .cycle_o(cycle), .rst_out_o(rst_out),
    .nmi_out_o(nmi_out), .irq_out_o(irq_out), .fetch_o(fetch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full visible state in one call: ir, cycle, rst/nmi/irq, fetch.
  task automatic chk_all(input string tag, input logic [7:0] e_ir, input logic [5:0] e_cyc,
                         input logic e_rst, input logic e_nmi, input logic e_irq, input logic e_f);
    chk({tag, ".ir"}, 32'(ir), 32'(e_ir));
    chk({tag, ".cycle"}, 32'(cycle), 32'(e_cyc));
    chk({tag, ".req"}, 32'({rst_out, nmi_out, irq_out}), 32'({e_rst, e_nmi, e_irq}));
    chk({tag, ".fetch"}, 32'(fetch), 32'(e_f));
  endtask

  initial begin
    reset = 1; rdy = 1; sync_next = 0; i_flag = 0; nmi_in = 0; irq_in = 0; din = 8'h00;
    repeat (3) tick();
    chk_all("reset", 8'h00, 6'b000001, 1, 0, 0, 1);

    reset = 0;
    tick(); chk_all("rst_c1", 8'h00, 6'b000010, 1, 0, 0, 0);
    tick(); chk("rst_c2", 32'(cycle), 32'h04);
    tick(); chk("rst_c3", 32'(cycle), 32'h08);
    tick(); chk_all("rst_c4", 8'h00, 6'b010000, 1, 0, 0, 0);
    sync_next = 1; din = 8'hA9;
    tick(); chk_all("rst_end", 8'hA9, 6'b000001, 0, 0, 0, 1);

    din = 8'hE8;
    tick(); chk_all("op_e8", 8'hE8, 6'b000001, 0, 0, 0, 1);
    sync_next = 0;
    tick(); chk_all("op_e8_c1", 8'hE8, 6'b000010, 0, 0, 0, 0);
    sync_next = 1; din = 8'hC8;
    tick(); chk_all("op_c8", 8'hC8, 6'b000001, 0, 0, 0, 1);

    irq_in = 1; i_flag = 1; din = 8'hEA;
    tick(); chk_all("irq_masked", 8'hEA, 6'b000001, 0, 0, 0, 1);
    i_flag = 0;
    tick(); chk_all("irq_taken", 8'h00, 6'b000001, 0, 0, 1, 1);
    irq_in = 0; sync_next = 0;
    tick(); chk_all("irq_c1", 8'h00, 6'b000010, 0, 0, 1, 0);
    sync_next = 1; din = 8'h4C;
    tick(); chk_all("irq_end", 8'h4C, 6'b000001, 0, 0, 0, 1);

    sync_next = 0; nmi_in = 1;
    tick(); chk("nmi_pulse_c1", 32'(nmi_out), 32'h0);
    nmi_in = 0;
    tick(); chk("nmi_pulse_c2", 32'(cycle), 32'h04);
    irq_in = 1; i_flag = 0; sync_next = 1; din = 8'hEA;
    tick(); chk_all("nmi_over_irq", 8'h00, 6'b000001, 0, 1, 0, 1);
    irq_in = 0;
    tick(); chk_all("nmi_once", 8'hEA, 6'b000001, 0, 0, 0, 1);

    nmi_in = 1; sync_next = 0;
    tick(); chk("nmi_hold_c1", 32'(cycle), 32'h02);
    sync_next = 1;
    tick(); chk_all("nmi_hold_take", 8'h00, 6'b000001, 0, 1, 0, 1);
    sync_next = 0;
    tick();
    sync_next = 1; din = 8'h18;
    tick(); chk_all("nmi_held_no2nd", 8'h18, 6'b000001, 0, 0, 0, 1);

    nmi_in = 0; sync_next = 0;
    tick();
    nmi_in = 1; sync_next = 1; din = 8'hEA;
    tick(); chk_all("nmi_edge_at_bnd", 8'hEA, 6'b000001, 0, 0, 0, 1);
    tick(); chk_all("nmi_edge_kept", 8'h00, 6'b000001, 0, 1, 0, 1);
    nmi_in = 0;

    sync_next = 0;
    tick(); tick(); chk("stall_pre", 32'(cycle), 32'h04);
    rdy = 0; sync_next = 1; din = 8'h69;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("stall", 8'h00, 6'b000100, 0, 1, 0, 0);
    end
    rdy = 1;
    tick(); chk_all("stall_release", 8'h69, 6'b000001, 0, 0, 0, 1);

    sync_next = 0;
    repeat (5) tick();
    chk("ovf_c5", 32'(cycle), 32'h20);
    tick(); chk_all("ovf", 8'h00, 6'b000000, 0, 0, 0, 0);
    sync_next = 1; din = 8'hA9;
    tick(); chk_all("ovf_recover", 8'hA9, 6'b000001, 0, 0, 0, 1);

    nmi_in = 1; sync_next = 0;
    tick();
    nmi_in = 0; sync_next = 1;
    tick(); chk("rnmi_take", 32'(nmi_out), 32'h1);
    sync_next = 0;
    tick(); tick(); chk_all("rnmi_c2", 8'h00, 6'b000100, 0, 1, 0, 0);
    reset = 1;
    tick(); chk_all("reset_mid_nmi", 8'h00, 6'b000001, 1, 0, 0, 1);
    reset = 0; nmi_in = 1;
    tick(); chk_all("rst_nmi_latch", 8'h00, 6'b000010, 1, 0, 0, 0);
    sync_next = 1; din = 8'hEA;
    tick(); chk_all("rst_then_nmi", 8'h00, 6'b000001, 0, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/k6502_seq.md
Name: k6502_seq

Overview:
- Instruction sequencer for the k6502 core.
- It is the producer side of the microcode lookup: it drives `ir`, the one-hot `cycle` and the rst/nmi/irq request lines into the microcode decoder.
- It consumes the decoder's SYNC NEXT bit to close one instruction and open the next.
- It owns opcode capture, cycle stepping, NMI edge detection, IRQ masking and interrupt priority arbitration.

Parameters:
- CYCLE_BITS, 6, width of one-hot cycle vector; C_0=bit0 … C_5=bit5, C_N=all zero.
- NMI_EDGE, 1, 1: nmi_in rising-edge latched; 0: nmi_in treated as level like IRQ.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- rdy  in  1  1: advance; 0: hold ir/cycle/request outputs (NMI edge latch still samples)
- din  in  8  data bus read value; opcode byte when sync_next is high
- sync_next  in  1  SYNC NEXT bit of current control word; current cycle is last of instruction
- i_flag  in  1  status register I bit; 1 masks irq_in
- nmi_in  in  1  NMI request, active-high
- irq_in  in  1  IRQ request, active-high level
- ir  out  8  instruction register to decoder
- cycle  out  CYCLE_BITS  one-hot cycle to decoder
- rst_out  out  1  reset sequence active (decoder rst input)
- nmi_out  out  1  NMI sequence active (decoder nmi input)
- irq_out  out  1  IRQ sequence active (decoder irq input)
- fetch  out  1  high in the C_0 cycle of every instruction or interrupt sequence

Behaviour:
- Reset, while reset=1 at edge:
  - ir=8'h00, cycle=C_0, rst_out=1, nmi_out=0, irq_out=0, fetch=1.
  - NMI pending cleared; NMI history register cleared to 0.
  - Reset overrides rdy.
- After release, rst_out stays 1 and cycle steps C_0→C_1→… until sync_next.
- At most one of rst_out/nmi_out/irq_out is 1 at any time.
- Cycle stepping, when rdy=1 and sync_next=0: cycle <= cycle<<1; ir unchanged.
- Overflow: sync_next=0 in C_5 gives cycle <= C_N, ir <= 8'h00, all request outputs 0. The decoder entry {none, 00, C_N} asserts sync_next, so the next edge recovers.
- Instruction boundary, when rdy=1 and sync_next=1, the next state is chosen by priority:
  1. NMI pending: ir <= 8'h00, nmi_out <= 1, NMI pending cleared.
  2. Else irq_in=1 and i_flag=0: ir <= 8'h00, irq_out <= 1.
  3. Else ir <= din; all request outputs 0.
- In every boundary case cycle <= C_0 and fetch <= 1.
- rst_out clears at the first boundary after reset; reset always beats NMI/IRQ.
- IRQ is sampled only at the boundary edge. Deassertion before the boundary means it is not taken; there is no latch.
- NMI with NMI_EDGE=1:
  - History register nmi_q <= nmi_in every edge, independent of rdy.
  - Pending set when nmi_in=1 and nmi_q=0.
  - Set beats clear on the same edge, so an edge arriving exactly at the boundary is kept pending.
  - An edge during an NMI sequence is held and taken at the next boundary.
  - The pending flag is held through rst_out, so an NMI latched during the reset sequence is taken at the first boundary after it.
- NMI with NMI_EDGE=0: pending = nmi_in, sampled at the boundary.
- rdy=0: ir, cycle, request outputs and fetch all hold, including across a boundary with sync_next=1. Only the NMI edge logic runs.
- fetch = (cycle==C_0), registered alongside cycle.
- Latency: exactly one clock from sync_next sampled high to new ir/cycle visible.

Test Plan:
- Reset, then release:
  - Hold reset 3 clks → ir=00, cycle=000001, rst_out=1.
  - Release with sync_next low 4 clks → cycle 000010, 000100, 001000, 010000.
  - sync_next=1, din=8'hA9 → next clk ir=A9, cycle=000001, rst_out=0, fetch=1.
- Normal instruction: ir=E8 at C_0; sync_next=1 at C_1 with din=C8 → ir=C8, cycle=000001 one clk later.
- IRQ masking:
  - irq_in=1, i_flag=1 at boundary, din=EA → ir=EA, irq_out=0.
  - Repeat with i_flag=0 → ir=00, irq_out=1, cycle=000001.
- NMI priority and edge:
  - Pulse nmi_in 1 clk mid-instruction; irq_in=1, i_flag=0 at boundary → nmi_out=1, irq_out=0.
  - Hold nmi_in high through the next boundary → no second NMI.
- rdy stall: rdy=0 for 3 clks at cycle=000100 with sync_next=1 → ir/cycle unchanged. Raise rdy → boundary taken on the next edge.
- Overflow recovery and reset mid-op:
  - sync_next=0 for 6 steps → cycle=000000, ir=00.
  - Assert reset during an NMI sequence at C_2 → ir=00, cycle=000001, rst_out=1, nmi_out=0.
